bcd_to_unsigned: RTL and testbench



---
 rtl/bcd_to_unsigned.sv | 134 +++++++++++++
 tb/tb_bcd_to_unsigned.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_unsigned.sv
// Sequential reverse double-dabble: 8-digit packed BCD in, 32-bit unsigned out.
// Optional per-digit validity check enabled by BCD_TO_UNSIGNED_DIGIT_CHECK_EN.
module bcd_to_unsigned (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [31:0] bcd,
  output logic        idle,
  output logic        done,
  output logic [31:0] bin
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
  ,
  output logic        invalid
`endif
);

  localparam int COUNTER_MAX = 32;
  localparam int DIGITS      = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_SUB3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] bcd_sr_q, bcd_sr_d;
  logic [31:0] bin_sr_q, bin_sr_d;
  logic [5:0]  counter_q, counter_d;
  logic [31:0] bin_q, bin_d;
  logic        done_q, done_d;
  logic [63:0] shifted;

`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
  logic        flag_q, flag_d;
  logic        invalid_q, invalid_d;
`endif

  assign shifted = {bcd_sr_q, bin_sr_q} >> 1;

  always_comb begin
    state_d   = state_q;
    bcd_sr_d  = bcd_sr_q;
    bin_sr_d  = bin_sr_q;
    counter_d = counter_q;
    bin_d     = bin_q;
    done_d    = 1'b0;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
    flag_d    = flag_q;
    invalid_d = invalid_q;
`endif

    case (state_q)
      S_IDLE: begin
        counter_d = 6'd1;
        if (trigger) begin
          bcd_sr_d = bcd;
          bin_sr_d = 32'd0;
          state_d  = S_SHIFT;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
          flag_d = 1'b0;
          for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) flag_d = 1'b1;
          end
`endif
        end
      end

      S_SHIFT: begin
        {bcd_sr_d, bin_sr_d} = shifted;
        counter_d = counter_q + 6'd1;
        if (counter_q == 6'(COUNTER_MAX)) begin
          bin_d   = shifted[31:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
          if (flag_q) begin
            bin_d     = 32'd0;
            invalid_d = 1'b1;
          end else begin
            invalid_d = 1'b0;
          end
`endif
        end else begin
          state_d = S_SUB3;
        end
      end

      S_SUB3: begin
        // A digit >= 8 after the shift carried a half-ten in; remove the extra 3.
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd_sr_q[4*i+3]) bcd_sr_d[4*i +: 4] = bcd_sr_q[4*i +: 4] - 4'd3;
        end
        state_d = S_SHIFT;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bcd_sr_q  <= 32'd0;
      bin_sr_q  <= 32'd0;
      counter_q <= 6'd0;
      bin_q     <= 32'd0;
      done_q    <= 1'b0;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
      flag_q    <= 1'b0;
      invalid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bcd_sr_q  <= bcd_sr_d;
      bin_sr_q  <= bin_sr_d;
      counter_q <= counter_d;
      bin_q     <= bin_d;
      done_q    <= done_d;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
      flag_q    <= flag_d;
      invalid_q <= invalid_d;
`endif
    end
  end

  assign idle = (state_q == S_IDLE);
  assign done = done_q;
  assign bin  = bin_q;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
  assign invalid = invalid_q;
`endif

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Self-checking bench for bcd_to_unsigned: vector table, cycle-timing checks and
// a scoreboard of expected results popped whenever done pulses.
module tb_bcd_to_unsigned;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic [31:0] bcd;
  logic        idle;
  logic        done;
  logic [31:0] bin;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
  logic        invalid;
`endif

  int errors = 0;
  int checks = 0;

  // bit 32 = expected invalid flag, bits 31:0 = expected bin
  logic [32:0] sb[$];

  typedef struct {
    logic [31:0] bcd;
    logic [31:0] exp;
  } vec_t;

  bcd_to_unsigned dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .bcd     (bcd),
    .idle    (idle),
    .done    (done),
    .bin     (bin)
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
    ,
    .invalid (invalid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding result.
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("bin_result", bin, e[31:0]);
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
          check("invalid_flag", {31'd0, invalid}, {31'd0, e[32]});
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished at %0t", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  // Caller is at posedge+#1 with idle=1. Runs n back-to-back conversions of b
  // (trigger held high across them when n>1). disturb changes bcd in cycle 5
  // and pulses trigger in cycle 10, both of which must be ignored.
  task automatic conv(input logic [31:0] b, input logic [31:0] e, input bit e_inv,
                      input int n, input bit disturb);
    int          bad_idle;
    int          bad_done;
    int          bad_hold;
    logic [31:0] prev_bin;
    trigger = 1'b1;
    bcd     = b;
    sb.push_back({e_inv, e});
    for (int k = 0; k < n; k++) begin
      bad_idle = 0;
      bad_done = 0;
      bad_hold = 0;
      prev_bin = bin;
      for (int c = 1; c <= 64; c++) begin
        @(posedge clk);
        #1;
        if (n == 1 && c == 1) trigger = 1'b0;
        if (disturb && c == 5) bcd = 32'h00000001;
        if (disturb && c == 10) trigger = 1'b1;
        if (disturb && c == 11) trigger = 1'b0;
        if (c < 64) begin
          if (idle !== 1'b0) bad_idle++;
          if (done !== 1'b0) bad_done++;
          if (bin !== prev_bin) bad_hold++;
        end else begin
          check("idle_at_64", {31'd0, idle}, 32'd1);
          check("done_at_64", {31'd0, done}, 32'd1);
          if (k < n - 1) sb.push_back({e_inv, e});
          else trigger = 1'b0;
        end
      end
      check("busy_idle_low", bad_idle, 0);
      check("busy_done_low", bad_done, 0);
      check("bin_held", bad_hold, 0);
    end
  endtask

  initial begin
    vec_t vecs[10];
    vecs[0] = '{32'h00000000, 32'h00000000};
    vecs[1] = '{32'h00000255, 32'h000000FF};
    vecs[2] = '{32'h12345678, 32'h00BC614E};
    vecs[3] = '{32'h99999999, 32'h05F5E0FF};
    vecs[4] = '{32'h00000009, 32'h00000009};
    vecs[5] = '{32'h00000010, 32'h0000000A};
    vecs[6] = '{32'h10000000, 32'h00989680};
    vecs[7] = '{32'h80000000, 32'h04C4B400};
    vecs[8] = '{32'h87654321, 32'h05397FB1};
    vecs[9] = '{32'h00000001, 32'h00000001};

    reset   = 1'b1;
    trigger = 1'b0;
    bcd     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_idle", {31'd0, idle}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bin", bin, 32'd0);
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
    check("reset_invalid", {31'd0, invalid}, 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      conv(vecs[i].bcd, vecs[i].exp, 1'b0, 1, 1'b0);
      @(posedge clk);
      #1;
    end

    // Input change and trigger mid-conversion must not affect anything.
    conv(32'h99999999, 32'h05F5E0FF, 1'b0, 1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("no_restart_idle", {31'd0, idle}, 32'd1);
    end

    // Trigger held high: three back-to-back conversions, idle high one cycle between.
    conv(32'h00000042, 32'h0000002A, 1'b0, 3, 1'b0);
    @(posedge clk);
    #1;
    check("after_b2b_idle", {31'd0, idle}, 32'd1);

    // Reset in cycle 30 aborts without done; bin returns to zero.
    conv(32'h00001000, 32'h000003E8, 1'b0, 1, 1'b0);
    @(posedge clk);
    #1;
    trigger = 1'b1;
    bcd     = 32'h00000007;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      trigger = 1'b0;
    end
    check("pre_abort_bin", bin, 32'h000003E8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_idle", {31'd0, idle}, 32'd1);
    check("abort_bin", bin, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (70) @(posedge clk);
    #1;
    check("abort_bin_stays", bin, 32'd0);
    conv(32'h00000007, 32'h00000007, 1'b0, 1, 1'b0);
    @(posedge clk);
    #1;

`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
    conv(32'h0000001A, 32'h00000000, 1'b1, 1, 1'b0);
    @(posedge clk);
    #1;
    check("invalid_holds", {31'd0, invalid}, 32'd1);
    conv(32'h00000019, 32'h00000013, 1'b0, 1, 1'b0);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
